port_out_dequeue: RTL and testbench

//  Output-side dequeue engine for one egress port. Round-robin arbitrates the 4 crossbar-buffer descriptor FIFOs

---
 rtl/port_out_dequeue.sv | 188 ++++++++++++++++++
 tb/tb_port_out_dequeue.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_out_dequeue.sv
// Egress-port dequeue engine: round-robin picks one of NUM_SRC descriptor
// FIFOs, walks the packet's unit chain in the shared MMU one unit at a time,
// streams each unit out with sop/eop, and returns every consumed unit address
// to the free pointer list on the same beat it is handed downstream.
module port_out_dequeue #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned NUM_SRC    = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_SRC-1:0]      i_cb_empty,
    output logic [NUM_SRC-1:0]      o_cb_rd_en,
    input  logic [NUM_SRC*32-1:0]   i_cb_dout,
    output logic                    o_mmu_rd_req,
    output logic [ADDR_WIDTH-1:0]   o_mmu_rd_addr,
    input  logic                    i_mmu_rd_ready,
    input  logic                    i_mmu_rd_valid,
    input  logic [DATA_WIDTH-1:0]   i_mmu_rd_dat,
    input  logic [ADDR_WIDTH-1:0]   i_mmu_rd_next,
    output logic                    o_fp_wr_en,
    output logic [ADDR_WIDTH-1:0]   o_fp_din,
    input  logic                    i_fp_full,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_dat,
    output logic                    o_sop,
    output logic                    o_eop,
    input  logic                    i_out_ready,
    output logic                    o_err
);

    localparam int unsigned DESC_W = 32;
    localparam int unsigned GW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_REQ,
        S_WAIT,
        S_OUT
    } state_t;

    state_t                  state_q;
    logic [GW-1:0]           rr_q;
    logic [GW-1:0]           grant_q;
    logic [7:0]              rem_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   next_q;
    logic                    first_q;
    logic                    req_q;
    logic                    valid_q;
    logic [DATA_WIDTH-1:0]   dat_q;
    logic                    sop_q;
    logic                    eop_q;
    logic                    err_q;

    logic [GW-1:0]           grant_d;
    logic                    found_d;
    logic [GW-1:0]           scan_idx;
    logic                    xfer;

    logic [DESC_W-1:0]       desc_w;
    logic [7:0]              desc_cnt;
    logic [ADDR_WIDTH-1:0]   desc_first;
    logic                    desc_unused;

    // Modulo-NUM_SRC increment that also works for non power-of-two source counts.
    function automatic logic [GW-1:0] rr_inc(input logic [GW-1:0] v);
        return (v == GW'(NUM_SRC - 1)) ? '0 : v + 1'b1;
    endfunction

    assign desc_w      = i_cb_dout[grant_q*DESC_W +: DESC_W];
    assign desc_cnt    = desc_w[ADDR_WIDTH +: 8];
    assign desc_first  = desc_w[ADDR_WIDTH-1:0];
    // Upper descriptor bits are reserved (always zero) and carry no meaning here.
    assign desc_unused = ^desc_w[DESC_W-1:ADDR_WIDTH+8];

    // Round-robin scan: first non-empty source at or after the rr pointer.
    always_comb begin
        grant_d  = rr_q;
        found_d  = 1'b0;
        scan_idx = rr_q;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (!found_d && !i_cb_empty[scan_idx]) begin
                found_d = 1'b1;
                grant_d = scan_idx;
            end
            scan_idx = rr_inc(scan_idx);
        end
    end

    // Descriptor pop pulse is combinational so the FIFO data lands during LATCH.
    always_comb begin
        o_cb_rd_en = '0;
        if (state_q == S_IDLE && found_d && !i_rst) begin
            o_cb_rd_en[grant_d] = 1'b1;
        end
    end

    // A beat leaves only when downstream and the free list can both take it.
    assign xfer       = (state_q == S_OUT) && i_out_ready && !i_fp_full && !i_rst;
    assign o_fp_wr_en = xfer;
    assign o_fp_din   = xfer ? addr_q : '0;

    assign o_mmu_rd_req  = req_q;
    assign o_mmu_rd_addr = addr_q;
    assign o_valid       = valid_q;
    assign o_dat         = dat_q;
    assign o_sop         = sop_q;
    assign o_eop         = eop_q;
    assign o_err         = err_q;

    // Main dequeue FSM with registered request/stream/error outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            rem_q   <= '0;
            addr_q  <= '0;
            next_q  <= '0;
            first_q <= 1'b0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            dat_q   <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        grant_q <= grant_d;
                        rr_q    <= rr_inc(grant_d);
                        state_q <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    rem_q   <= desc_cnt;
                    addr_q  <= desc_first;
                    first_q <= 1'b1;
                    if (desc_cnt == 8'd0) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        req_q   <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_mmu_rd_ready) begin
                        req_q   <= 1'b0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_mmu_rd_valid) begin
                        dat_q   <= i_mmu_rd_dat;
                        next_q  <= i_mmu_rd_next;
                        valid_q <= 1'b1;
                        sop_q   <= first_q;
                        eop_q   <= (rem_q == 8'd1);
                        state_q <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (i_out_ready && !i_fp_full) begin
                        valid_q <= 1'b0;
                        sop_q   <= 1'b0;
                        eop_q   <= 1'b0;
                        first_q <= 1'b0;
                        rem_q   <= rem_q - 8'd1;
                        if (rem_q == 8'd1) begin
                            state_q <= S_IDLE;
                        end else begin
                            addr_q  <= next_q;
                            req_q   <= 1'b1;
                            state_q <= S_REQ;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_port_out_dequeue.sv
// Randomized bench for port_out_dequeue: descriptor FIFOs, MMU and free list
// are modelled here; the expected beat/error stream is derived from packet-level
// round-robin order and the unit link chains.
module tb_port_out_dequeue;

    localparam int unsigned NS = 4;

    typedef struct {
        logic        err;
        logic [31:0] dat;
        logic        sop;
        logic        eop;
        logic [16:0] fa;
    } exp_t;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [NS-1:0] i_cb_empty;
    logic [NS-1:0] o_cb_rd_en;
    logic [NS*32-1:0] i_cb_dout;
    logic          o_mmu_rd_req;
    logic [16:0]   o_mmu_rd_addr;
    logic          i_mmu_rd_ready;
    logic          i_mmu_rd_valid;
    logic [31:0]   i_mmu_rd_dat;
    logic [16:0]   i_mmu_rd_next;
    logic          o_fp_wr_en;
    logic [16:0]   o_fp_din;
    logic          i_fp_full;
    logic          o_valid;
    logic [31:0]   o_dat;
    logic          o_sop;
    logic          o_eop;
    logic          i_out_ready;
    logic          o_err;

    port_out_dequeue #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (17),
        .NUM_SRC    (NS)
    ) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_cb_empty     (i_cb_empty),
        .o_cb_rd_en     (o_cb_rd_en),
        .i_cb_dout      (i_cb_dout),
        .o_mmu_rd_req   (o_mmu_rd_req),
        .o_mmu_rd_addr  (o_mmu_rd_addr),
        .i_mmu_rd_ready (i_mmu_rd_ready),
        .i_mmu_rd_valid (i_mmu_rd_valid),
        .i_mmu_rd_dat   (i_mmu_rd_dat),
        .i_mmu_rd_next  (i_mmu_rd_next),
        .o_fp_wr_en     (o_fp_wr_en),
        .o_fp_din       (o_fp_din),
        .i_fp_full      (i_fp_full),
        .o_valid        (o_valid),
        .o_dat          (o_dat),
        .o_sop          (o_sop),
        .o_eop          (o_eop),
        .i_out_ready    (i_out_ready),
        .o_err          (o_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    exp_t        expq[$];
    logic [31:0] srcq[NS][$];
    logic [31:0] mem_dat[int];
    logic [16:0] mem_next[int];
    logic        used[int];
    int          model_rr = 0;
    int          rdcnt[NS];
    int          beats = 0;

    int          p_ready = 100;
    int          p_full = 0;
    int          p_mready = 100;
    int          max_lat = 0;
    logic        stray_en = 1'b0;

    int          pend_pop = -1;
    logic        acc = 1'b0;
    logic [16:0] acc_addr = '0;
    logic        mpend = 1'b0;
    int          mlat = 0;
    logic [16:0] m_addr = '0;
    logic        held = 1'b0;
    logic [31:0] h_dat = '0;
    logic        h_sop = 1'b0;
    logic        h_eop = 1'b0;
    logic        rq_held = 1'b0;
    logic [16:0] rq_addr = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int alloc_addr();
        int a;
        do a = int'($urandom_range(0, 131071)); while (used.exists(a));
        used[a] = 1'b1;
        return a;
    endfunction

    function automatic void update_empty();
        for (int unsigned s = 0; s < NS; s++) i_cb_empty[s] = (srcq[s].size() == 0);
    endfunction

    function automatic logic any_src();
        for (int unsigned s = 0; s < NS; s++) if (srcq[s].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Store a chain in MMU memory and queue its descriptor on a source.
    function automatic void add_chain(input int src, input int addrs[$]);
        int n = addrs.size();
        logic [31:0] d = '0;
        for (int i = 0; i < n; i++) begin
            used[addrs[i]] = 1'b1;
            mem_dat[addrs[i]] = $urandom;
            mem_next[addrs[i]] = (i + 1 < n) ? 17'(addrs[i+1]) : 17'($urandom);
        end
        d[24:17] = 8'(n);
        d[16:0]  = (n > 0) ? 17'(addrs[0]) : 17'($urandom);
        srcq[src].push_back(d);
    endfunction

    function automatic void add_rand(input int src, input int cnt);
        int a[$];
        for (int i = 0; i < cnt; i++) a.push_back(alloc_addr());
        add_chain(src, a);
    endfunction

    // Packet-level round robin over the queued descriptors -> expected stream.
    function automatic void build_expect();
        logic [31:0] tq[NS][$];
        logic [31:0] d;
        int g, cnt, a;
        exp_t e;
        for (int unsigned s = 0; s < NS; s++) tq[s] = srcq[s];
        forever begin
            g = -1;
            for (int k = 0; k < int'(NS); k++) begin
                if (g < 0 && tq[(model_rr + k) % NS].size() != 0) g = (model_rr + k) % NS;
            end
            if (g < 0) break;
            d = tq[g].pop_front();
            model_rr = (g + 1) % NS;
            cnt = int'(d[24:17]);
            a = int'(d[16:0]);
            if (cnt == 0) begin
                e.err = 1'b1; e.dat = '0; e.sop = 1'b0; e.eop = 1'b0; e.fa = '0;
                expq.push_back(e);
            end
            for (int i = 0; i < cnt; i++) begin
                e.err = 1'b0;
                e.dat = mem_dat[a];
                e.sop = (i == 0);
                e.eop = (i == cnt - 1);
                e.fa  = 17'(a);
                expq.push_back(e);
                a = int'(mem_next[a]);
            end
        end
    endfunction

    task automatic cycle();
        logic xfer;
        exp_t e;
        @(negedge clk);
        xfer = o_valid && i_out_ready && !i_fp_full;
        chk("fp_wr_en", o_fp_wr_en, xfer);
        if (held) begin
            chk("hold_valid", o_valid, 1);
            chk("hold_dat", o_dat, h_dat);
            chk("hold_sop", o_sop, h_sop);
            chk("hold_eop", o_eop, h_eop);
        end
        held = o_valid && !xfer;
        h_dat = o_dat; h_sop = o_sop; h_eop = o_eop;
        if (xfer) begin
            beats++;
            chk("beat_expected", expq.size() > 0, 1);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("beat_not_err", e.err, 0);
                chk("dat", o_dat, e.dat);
                chk("sop", o_sop, e.sop);
                chk("eop", o_eop, e.eop);
                chk("fp_din", o_fp_din, e.fa);
            end
        end
        if (o_err) begin
            chk("err_expected", expq.size() > 0, 1);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("err_item", e.err, 1);
            end
        end
        pend_pop = -1;
        if (o_cb_rd_en != '0) begin
            chk("rd_onehot", $onehot(o_cb_rd_en), 1);
            for (int s = 0; s < int'(NS); s++) begin
                if (o_cb_rd_en[s]) begin
                    chk("rd_nonempty", i_cb_empty[s], 0);
                    pend_pop = s;
                    rdcnt[s]++;
                end
            end
        end
        if (rq_held) begin
            chk("req_hold", o_mmu_rd_req, 1);
            chk("req_addr_hold", o_mmu_rd_addr, rq_addr);
        end
        rq_held  = o_mmu_rd_req && !i_mmu_rd_ready;
        rq_addr  = o_mmu_rd_addr;
        acc      = o_mmu_rd_req && i_mmu_rd_ready;
        acc_addr = o_mmu_rd_addr;

        @(posedge clk);
        #1;
        if (pend_pop >= 0 && srcq[pend_pop].size() > 0)
            i_cb_dout[pend_pop*32 +: 32] = srcq[pend_pop].pop_front();
        update_empty();
        if (acc) begin
            mpend = 1'b1;
            mlat = int'($urandom_range(0, max_lat));
            m_addr = acc_addr;
        end
        if (mpend) begin
            if (mlat == 0) begin
                i_mmu_rd_valid = 1'b1;
                i_mmu_rd_dat   = mem_dat.exists(int'(m_addr)) ? mem_dat[int'(m_addr)] : $urandom;
                i_mmu_rd_next  = mem_next.exists(int'(m_addr)) ? mem_next[int'(m_addr)] : 17'($urandom);
                mpend = 1'b0;
            end else begin
                mlat--;
                i_mmu_rd_valid = 1'b0;
            end
        end else begin
            i_mmu_rd_valid = stray_en && ($urandom_range(0, 3) == 0);
            i_mmu_rd_dat   = $urandom;
            i_mmu_rd_next  = 17'($urandom);
        end
        i_mmu_rd_ready = ($urandom_range(0, 99) < p_mready);
        i_out_ready    = ($urandom_range(0, 99) < p_ready);
        i_fp_full      = ($urandom_range(0, 99) < p_full);
    endtask

    task automatic run_phase(input int limit);
        int n = 0;
        update_empty();
        build_expect();
        while ((expq.size() != 0 || any_src()) && n < limit) begin
            cycle();
            n++;
        end
        chk("phase_drained", expq.size(), 0);
        repeat (4) cycle();
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        for (int unsigned s = 0; s < NS; s++) srcq[s].delete();
        expq.delete();
        update_empty();
        mpend = 1'b0; acc = 1'b0; held = 1'b0; rq_held = 1'b0; pend_pop = -1;
        i_mmu_rd_valid = 1'b0;
        model_rr = 0;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        @(negedge clk);
        chk("rst_cb_rd_en", o_cb_rd_en, 0);
        chk("rst_mmu_req", o_mmu_rd_req, 0);
        chk("rst_mmu_addr", o_mmu_rd_addr, 0);
        chk("rst_fp_wr_en", o_fp_wr_en, 0);
        chk("rst_fp_din", o_fp_din, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_dat", o_dat, 0);
        chk("rst_sop", o_sop, 0);
        chk("rst_eop", o_eop, 0);
        chk("rst_err", o_err, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic set_knobs(input int rdy, input int full, input int mrdy, input int lat, input logic stray);
        p_ready = rdy; p_full = full; p_mready = mrdy; max_lat = lat; stray_en = stray;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int n;
        i_cb_empty = '1; i_cb_dout = '0;
        i_mmu_rd_ready = 1'b1; i_mmu_rd_valid = 1'b0; i_mmu_rd_dat = '0; i_mmu_rd_next = '0;
        i_fp_full = 1'b0; i_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Three-unit packet on src0 through a fixed chain, no back-pressure.
        set_knobs(100, 0, 100, 0, 1'b0);
        for (int unsigned s = 0; s < NS; s++) rdcnt[s] = 0;
        add_chain(0, '{32'h10, 32'h22, 32'h05});
        run_phase(200);
        chk("rd_cnt_src0", rdcnt[0], 1);
        chk("rd_cnt_src1", rdcnt[1], 0);

        // One single-unit packet per source from rr=0.
        do_reset();
        for (int s = 0; s < int'(NS); s++) add_rand(s, 1);
        run_phase(300);

        // Four-unit packet under downstream and free-list back-pressure.
        set_knobs(40, 30, 100, 0, 1'b0);
        add_rand(1, 4);
        run_phase(500);

        // Zero-length descriptor on src2 followed by src3.
        do_reset();
        set_knobs(100, 0, 100, 0, 1'b0);
        add_rand(2, 0);
        add_rand(3, 2);
        run_phase(200);

        // Slow MMU acceptance with stray read-valid pulses.
        set_knobs(100, 0, 20, 2, 1'b1);
        add_rand(0, 3);
        add_rand(2, 2);
        run_phase(800);

        // Reset mid-packet after two beats, then a fresh packet.
        do_reset();
        set_knobs(100, 0, 100, 0, 1'b0);
        add_rand(1, 5);
        update_empty();
        build_expect();
        beats = 0;
        n = 0;
        while (beats < 2 && n < 200) begin
            cycle();
            n++;
        end
        chk("rst_phase_beats", beats, 2);
        do_reset();
        add_rand(3, 2);
        run_phase(200);

        // Randomized mixes of descriptors and back-pressure.
        for (int r = 0; r < 8; r++) begin
            set_knobs(int'($urandom_range(30, 100)), int'($urandom_range(0, 30)),
                      int'($urandom_range(30, 100)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            for (int s = 0; s < int'(NS); s++) begin
                repeat ($urandom_range(0, 3)) add_rand(s, int'($urandom_range(0, 6)));
            end
            run_phase(4000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
